multi_mode_shift_register: RTL and testbench

Parametrised, command-driven shift register and the successor to the single-direction shift register. It shifts by STEP bits per shift in one of four run-time modes: logical left/right and rotate left/right, with optional arithmetic right. A start/count command runs a multi-cycle shift sequence under an FSM, with busy/done/err status. It sits in datapaths that need serialisation, rotation or scaling without a combinational barrel shifter.

---
 rtl/multi_mode_shift_register_pkg.sv | 35 +++
 rtl/shift_step_unit.sv | 82 ++++++++
 rtl/multi_mode_shift_register.sv | 156 +++++++++++++++
 tb/tb_multi_mode_shift_register.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_mode_shift_register_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for multi_mode_shift_register and shift_step_unit:
//   - mode encodings (MODE_LSL, MODE_LSR, MODE_ROL, MODE_ROR, MODE_ASR)
//   - FSM state encoding (ST_IDLE, ST_SHIFT)
//   - mode_is_legal(): reports whether a mode code is supported by this build
// Build option: SHIFT_ARITH_EN -- when defined, mode 3'b100 is arithmetic
// shift right; when undefined it is an illegal mode.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ROL = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic mode_is_legal(input logic [2:0] m);
        logic legal;
        case (m)
            MODE_LSL, MODE_LSR, MODE_ROL, MODE_ROR: legal = 1'b1;
`ifdef SHIFT_ARITH_EN
            MODE_ASR:                               legal = 1'b1;
`endif
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// ---------------------------------------------------------------------------
// shift_step_unit
// Combinational single-step shifter: given the current register value, the
// latched mode and the fill bits, produces the register value and expelled
// bits after one STEP-bit shift.
// Parameters: WIDTH (register width), STEP (bits per shift, 1..WIDTH-1)
// Ports:
//   q             in  WIDTH  current register contents
//   mode          in  3      shift mode (shift_pkg encoding)
//   shiftin       in  STEP   fill bits for logical shifts
//   q_step        out WIDTH  register contents after the shift
//   shiftout_step out STEP   bits expelled by the shift
// Build option: SHIFT_ARITH_EN enables the sign-fill (ASR) path.
// ---------------------------------------------------------------------------
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [STEP-1:0]  shiftin,
    output logic [WIDTH-1:0] q_step,
    output logic [STEP-1:0]  shiftout_step
);

    logic [STEP-1:0]       hi_bits;     // bits leaving on a left shift
    logic [STEP-1:0]       lo_bits;     // bits leaving on a right shift
    logic [WIDTH-STEP-1:0] keep_left;   // bits that survive a left shift
    logic [WIDTH-STEP-1:0] keep_right;  // bits that survive a right shift

    assign hi_bits    = q[WIDTH-1 -: STEP];
    assign lo_bits    = q[STEP-1:0];
    assign keep_left  = q[WIDTH-STEP-1:0];
    assign keep_right = q[WIDTH-1:STEP];

`ifdef SHIFT_ARITH_EN
    logic [STEP-1:0] sign_fill;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_sign_fill
            assign sign_fill[gi] = q[WIDTH-1];
        end
    endgenerate
`endif

    always_comb begin
        q_step        = q;
        shiftout_step = '0;
        case (mode)
            MODE_LSL: begin
                q_step        = {keep_left, shiftin};
                shiftout_step = hi_bits;
            end
            MODE_LSR: begin
                q_step        = {shiftin, keep_right};
                shiftout_step = lo_bits;
            end
            MODE_ROL: begin
                q_step        = {keep_left, hi_bits};
                shiftout_step = hi_bits;
            end
            MODE_ROR: begin
                q_step        = {lo_bits, keep_right};
                shiftout_step = lo_bits;
            end
`ifdef SHIFT_ARITH_EN
            MODE_ASR: begin
                q_step        = {sign_fill, keep_right};
                shiftout_step = lo_bits;
            end
`endif
            default: begin
                // Unreachable in practice: illegal modes are never latched.
                q_step        = q;
                shiftout_step = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_mode_shift_register.sv
// ---------------------------------------------------------------------------
// multi_mode_shift_register
// Command-driven shift register: a start/count command runs a multi-cycle
// sequence of STEP-bit shifts in one of several modes (LSL, LSR, ROL, ROR,
// optionally ASR), with busy/done/err status.
// Parameters: WIDTH, STEP, CNT_W (count width), LOAD_SVALUE (sset value)
// Ports:
//   clock    in   sole clock, rising edge
//   sclr     in   synchronous active-high reset, overrides everything
//   enable   in   clock enable (done/err clearing is not gated)
//   sset     in   q <- LOAD_SVALUE (highest priority under enable)
//   load     in   q <- data
//   data     in   parallel load value
//   start    in   command strobe, accepted in IDLE only
//   mode     in   shift mode
//   count    in   number of shifts
//   shiftin  in   fill bits for logical shifts, sampled on each shift edge
//   q        out  register contents
//   shiftout out  bits expelled by the most recent shift
//   busy     out  high while a sequence is running
//   done     out  one-cycle completion pulse
//   err      out  one-cycle pulse on start with an illegal mode
// Build option: SHIFT_ARITH_EN -- enables mode 3'b100 (arithmetic right).
// ---------------------------------------------------------------------------
module multi_mode_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STEP        = 1,
    parameter int CNT_W       = 4,
    parameter int LOAD_SVALUE = 1
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             enable,
    input  logic             sset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [STEP-1:0]  shiftin,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  shiftout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] SVALUE = WIDTH'(LOAD_SVALUE);

    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [2:0]       mode_reg,      mode_next;
    logic [WIDTH-1:0] q_reg,         q_next;
    logic [STEP-1:0]  shiftout_reg,  shiftout_next;
    logic             done_reg,      done_next;
    logic             err_reg,       err_next;

    logic [WIDTH-1:0] q_step;
    logic [STEP-1:0]  shiftout_step;

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .q             (q_reg),
        .mode          (mode_reg),
        .shiftin       (shiftin),
        .q_step        (q_step),
        .shiftout_step (shiftout_step)
    );

    // State register
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            mode_reg      <= MODE_LSL;
            q_reg         <= '0;
            shiftout_reg  <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            mode_reg      <= mode_next;
            q_reg         <= q_next;
            shiftout_reg  <= shiftout_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic. done/err default low so they are single-cycle pulses
    // even while enable is low.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        mode_next      = mode_reg;
        q_next         = q_reg;
        shiftout_next  = shiftout_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        if (enable) begin
            if (sset) begin
                q_next        = SVALUE;
                shiftout_next = '0;
                state_next    = ST_IDLE;
            end else if (load) begin
                q_next        = data;
                shiftout_next = '0;
                state_next    = ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            if (mode_is_legal(mode)) begin
                                mode_next = mode;
                                if (count == '0) begin
                                    done_next = 1'b1;
                                end else begin
                                    state_next     = ST_SHIFT;
                                    remaining_next = count;
                                end
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        q_next         = q_step;
                        shiftout_next  = shiftout_step;
                        remaining_next = remaining_reg - CNT_W'(1);
                        if (remaining_reg == CNT_W'(1)) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        q        = q_reg;
        shiftout = shiftout_reg;
        busy     = (state_reg == ST_SHIFT);
        done     = done_reg;
        err      = err_reg;
    end

endmodule

// File: tb/tb_multi_mode_shift_register.sv
// ---------------------------------------------------------------------------
// tb_multi_mode_shift_register
// Directed, table-driven bench for multi_mode_shift_register. u_dut is the
// WIDTH=8/STEP=1 instance driven by the vector table; u_dut2 is a STEP=2
// instance sharing the control inputs, checked by a short hand sequence.
// ---------------------------------------------------------------------------
module tb_multi_mode_shift_register;

    logic       clock = 1'b0;
    logic       sclr, enable, sset, load, start;
    logic [7:0] data, data2;
    logic [2:0] mode;
    logic [3:0] count;
    logic       shiftin;
    logic [1:0] shiftin2;
    logic [7:0] q, q2;
    logic       shiftout;
    logic [1:0] shiftout2;
    logic       busy, done, err, busy2, done2, err2;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    multi_mode_shift_register #(.WIDTH(8), .STEP(1), .CNT_W(4), .LOAD_SVALUE(1)) u_dut (
        .clock(clock), .sclr(sclr), .enable(enable), .sset(sset), .load(load),
        .data(data), .start(start), .mode(mode), .count(count), .shiftin(shiftin),
        .q(q), .shiftout(shiftout), .busy(busy), .done(done), .err(err)
    );

    multi_mode_shift_register #(.WIDTH(8), .STEP(2), .CNT_W(4), .LOAD_SVALUE(1)) u_dut2 (
        .clock(clock), .sclr(sclr), .enable(enable), .sset(sset), .load(load),
        .data(data2), .start(start), .mode(mode), .count(count), .shiftin(shiftin2),
        .q(q2), .shiftout(shiftout2), .busy(busy2), .done(done2), .err(err2)
    );

    typedef struct {
        logic       sclr, en, sset, ld;
        logic [7:0] d;
        logic       st;
        logic [2:0] m;
        logic [3:0] c;
        logic       si;
        logic [7:0] eq;
        logic       esh, eb, ed, ee;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic sc, en, ss, ld, input logic [7:0] d, input logic st,
                     input logic [2:0] m, input logic [3:0] c, input logic si,
                     input logic [7:0] eq, input logic esh, eb, ed, ee);
        vec_t x;
        x.sclr = sc; x.en = en; x.sset = ss; x.ld = ld; x.d = d; x.st = st;
        x.m = m; x.c = c; x.si = si; x.eq = eq; x.esh = esh; x.eb = eb; x.ed = ed; x.ee = ee;
        vecs.push_back(x);
    endtask

    // Shorthands: one clock of idle, load or start with enable high.
    task automatic vi(input logic si, input logic [7:0] eq, input logic esh, eb, ed, ee);
        v(0, 1, 0, 0, 8'h00, 0, 3'd0, 4'd0, si, eq, esh, eb, ed, ee);
    endtask
    task automatic vl(input logic [7:0] d);
        v(0, 1, 0, 1, d, 0, 3'd0, 4'd0, 0, d, 0, 0, 0, 0);
    endtask
    task automatic vs(input logic [2:0] m, input logic [3:0] c, input logic si,
                      input logic [7:0] eq, input logic esh, eb, ed, ee);
        v(0, 1, 0, 0, 8'h00, 1, m, c, si, eq, esh, eb, ed, ee);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive_idle();
        sclr = 0; enable = 1; sset = 0; load = 0; start = 0;
        data = 8'h00; mode = 3'd0; count = 4'd0; shiftin = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        data2 = 8'h00; shiftin2 = 2'b00;
        drive_idle();
        sclr = 1;

        // Reset, and reset overriding a disabled load
        v(1, 1, 0, 0, 8'h00, 0, 3'd0, 4'd0, 0, 8'h00, 0, 0, 0, 0);
        v(1, 0, 0, 1, 8'hFF, 0, 3'd0, 4'd0, 0, 8'h00, 0, 0, 0, 0);
        // LSL x3 from A5, shiftin=1
        vl(8'hA5);
        vs(3'd0, 4'd3, 1, 8'hA5, 0, 1, 0, 0);
        vi(1, 8'h4B, 1, 1, 0, 0);
        vi(1, 8'h97, 0, 1, 0, 0);
        vi(1, 8'h2F, 1, 0, 1, 0);
        vi(1, 8'h2F, 1, 0, 0, 0);
        // count=0: immediate done, no busy
        vs(3'd0, 4'd0, 0, 8'h2F, 1, 0, 1, 0);
        vi(0, 8'h2F, 1, 0, 0, 0);
        // ROR x8 from A5 returns to A5
        vl(8'hA5);
        vs(3'd3, 4'd8, 0, 8'hA5, 0, 1, 0, 0);
        vi(0, 8'hD2, 1, 1, 0, 0);
        vi(0, 8'h69, 0, 1, 0, 0);
        vi(0, 8'hB4, 1, 1, 0, 0);
        vi(0, 8'h5A, 0, 1, 0, 0);
        vi(0, 8'h2D, 0, 1, 0, 0);
        vi(0, 8'h96, 1, 1, 0, 0);
        vi(0, 8'h4B, 0, 1, 0, 0);
        vi(0, 8'hA5, 1, 0, 1, 0);
        vi(0, 8'hA5, 1, 0, 0, 0);
        // ASR x2 from 90 (build dependent)
        vl(8'h90);
`ifdef SHIFT_ARITH_EN
        vs(3'd4, 4'd2, 0, 8'h90, 0, 1, 0, 0);
        vi(0, 8'hC8, 0, 1, 0, 0);
        vi(0, 8'hE4, 0, 0, 1, 0);
`else
        vs(3'd4, 4'd2, 0, 8'h90, 0, 0, 0, 1);
        vi(0, 8'h90, 0, 0, 0, 0);
        vi(0, 8'h90, 0, 0, 0, 0);
`endif
        // Illegal mode 101
        vl(8'h55);
        vs(3'd5, 4'd3, 0, 8'h55, 0, 0, 0, 1);
        vi(0, 8'h55, 0, 0, 0, 0);
        // LSR x5 from FF aborted by load at the 2nd shift edge
        vl(8'hFF);
        vs(3'd1, 4'd5, 0, 8'hFF, 0, 1, 0, 0);
        vi(0, 8'h7F, 1, 1, 0, 0);
        vl(8'h3C);
        vi(0, 8'h3C, 0, 0, 0, 0);
        vi(0, 8'h3C, 0, 0, 0, 0);
        vs(3'd0, 4'd1, 0, 8'h3C, 0, 1, 0, 0);
        vi(0, 8'h78, 0, 0, 1, 0);
        // Enable dropped for 2 cycles; start during SHIFT ignored
        vl(8'h01);
        vs(3'd0, 4'd3, 0, 8'h01, 0, 1, 0, 0);
        vi(0, 8'h02, 0, 1, 0, 0);
        v(0, 0, 0, 0, 8'h00, 1, 3'd3, 4'd1, 0, 8'h02, 0, 1, 0, 0);
        v(0, 0, 0, 0, 8'h00, 0, 3'd0, 4'd0, 0, 8'h02, 0, 1, 0, 0);
        vs(3'd3, 4'd1, 0, 8'h04, 0, 1, 0, 0);
        vi(0, 8'h08, 0, 0, 1, 0);
        // done clears with enable low; load blocked by enable low
        v(0, 0, 0, 0, 8'h00, 0, 3'd0, 4'd0, 0, 8'h08, 0, 0, 0, 0);
        v(0, 0, 0, 1, 8'hFF, 0, 3'd0, 4'd0, 0, 8'h08, 0, 0, 0, 0);
        // sset beats load
        v(0, 1, 1, 1, 8'hFF, 0, 3'd0, 4'd0, 0, 8'h01, 0, 0, 0, 0);
        // sclr mid ROL sequence
        vl(8'h81);
        vs(3'd2, 4'd4, 0, 8'h81, 0, 1, 0, 0);
        vi(0, 8'h03, 1, 1, 0, 0);
        v(1, 1, 0, 0, 8'h00, 0, 3'd0, 4'd0, 0, 8'h00, 0, 0, 0, 0);
        vi(0, 8'h00, 0, 0, 0, 0);
        vi(0, 8'h00, 0, 0, 0, 0);
        // sset aborts an LSR sequence
        vl(8'h80);
        vs(3'd1, 4'd3, 1, 8'h80, 0, 1, 0, 0);
        vi(1, 8'hC0, 0, 1, 0, 0);
        v(0, 1, 1, 0, 8'h00, 0, 3'd0, 4'd0, 0, 8'h01, 0, 0, 0, 0);
        vi(0, 8'h01, 0, 0, 0, 0);
        // err pulse clears with enable low
        vs(3'd6, 4'd1, 0, 8'h01, 0, 0, 0, 1);
        v(0, 0, 0, 0, 8'h00, 0, 3'd0, 4'd0, 0, 8'h01, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            sclr = vecs[i].sclr; enable = vecs[i].en; sset = vecs[i].sset; load = vecs[i].ld;
            data = vecs[i].d; start = vecs[i].st; mode = vecs[i].m; count = vecs[i].c;
            shiftin = vecs[i].si;
            tick();
            chk($sformatf("v%0d q", i),        32'(q),        32'(vecs[i].eq));
            chk($sformatf("v%0d shiftout", i), 32'(shiftout), 32'(vecs[i].esh));
            chk($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].eb));
            chk($sformatf("v%0d done", i),     32'(done),     32'(vecs[i].ed));
            chk($sformatf("v%0d err", i),      32'(err),      32'(vecs[i].ee));
        end

        // LSR count=10 (> WIDTH): register fills entirely from shiftin
        @(negedge clock); drive_idle(); load = 1; data = 8'h00;
        @(negedge clock); drive_idle(); start = 1; mode = 3'd1; count = 4'd10; shiftin = 1;
        @(negedge clock); drive_idle(); shiftin = 1;
        repeat (9) @(negedge clock);
        #1;
        chk("lsr10 busy before last", 32'(busy), 32'd1);
        tick();
        chk("lsr10 q", 32'(q), 32'hFF);
        chk("lsr10 done", 32'(done), 32'd1);

        // ROL count=9 from 81 wraps to a single rotate
        @(negedge clock); drive_idle(); load = 1; data = 8'h81;
        @(negedge clock); drive_idle(); start = 1; mode = 3'd2; count = 4'd9;
        @(negedge clock); drive_idle();
        repeat (8) @(negedge clock);
        tick();
        chk("rol9 q", 32'(q), 32'h03);
        chk("rol9 done", 32'(done), 32'd1);

        // STEP=2 instance: LSR x1 from F0 with shiftin 01
        @(negedge clock); drive_idle(); sclr = 1;
        tick();
        chk("step2 reset q", 32'(q2), 32'h00);
        @(negedge clock); drive_idle(); load = 1; data2 = 8'hF0;
        @(negedge clock); drive_idle(); start = 1; mode = 3'd1; count = 4'd1; shiftin2 = 2'b01;
        tick();
        chk("step2 busy", 32'(busy2), 32'd1);
        @(negedge clock); drive_idle(); shiftin2 = 2'b01;
        tick();
        chk("step2 q", 32'(q2), 32'h7C);
        chk("step2 shiftout", 32'(shiftout2), 32'h0);
        chk("step2 done", 32'(done2), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
